com_cc_tx: RTL and testbench
============================

# com_cc_tx

Serial line transmitter for the com link. It accepts bytes from the local side over a valid/ready handshake. Each byte goes out on a single pin as a framed sequence of fixed-length bit cells, with every bit held for CELL clocks. It pairs with the com_cc receive path, which locks onto the first high cell and then majority-votes samples inside each CELL-clock window.

## Interface
- CELL, 4, clocks per bit cell; must be ≥ 2; cell counter width is $clog2(CELL)
- LEAD, 2, number of idle-low cells forced after reset before the first byte is accepted
- clk  input  1  system clock, same clock as the receive-side cell counter
- fire  input  1  reset, asynchronous and active-low; low resets the block immediately, release is sampled on clk
- tx_data  input  8  byte to send, sampled on the accept edge
- tx_valid  input  1  tx_data is valid
- tx_ready  output  1  block can accept a byte this cycle
- pin_txd  output  1  serial line, registered
- busy  output  1  high while a frame (start/data/stop) is on the line

## Operation
- Frame = 10 cells: start cell (1), 8 data cells MSB first, stop cell (0).
- Idle line is 0.
- States: LEAD, READY, START, DATA, STOP.
  - LEAD: pin_txd=0; counts LEAD×CELL clocks, then goes to READY.
  - READY: pin_txd=0, tx_ready=1. On tx_valid&tx_ready: latch tx_data into an 8-bit shift register, clear cell/bit counters, go to START.
  - START: pin_txd=1 for CELL clocks, then go to DATA.
  - DATA: pin_txd=shift[7] for CELL clocks per bit. Shift left at each cell end. Bit counter runs 0..7; after bit 7 go to STOP.
  - STOP: pin_txd=0 for CELL clocks. tx_ready=1 during the final clock of STOP only.
    - If a byte is accepted there, go directly to START (no extra idle cell).
    - Otherwise go to READY.
- tx_ready is 0 in LEAD, START, DATA and in every STOP clock except the last.
- A byte is consumed only on the edge where tx_valid=1 and tx_ready=1. tx_data changes at other times are ignored.
- busy=1 in START, DATA, STOP; 0 in LEAD and READY.
- No FIFO. Backpressure is tx_ready only.

## Timing
- Reset values (fire low): state=LEAD, pin_txd=0, tx_ready=0, busy=0, shift register=0, counters=0.
- First tx_ready=1 occurs LEAD×CELL clocks after the first clk edge with fire high (8 clocks at defaults).
- Accept at edge k: pin_txd=1 and busy=1 from edge k+1.
- The start cell occupies edges k+1..k+CELL.
- Data bit i (i=0 is MSB) occupies clocks k+1+CELL×(1+i) .. k+CELL×(2+i).
- The stop cell ends at clock k+10×CELL. Frame length is exactly 10×CELL clocks (40 at default).
- Back-to-back: accept on the last STOP clock. The next start cell begins the following clock. Sustained rate is 1 byte per 10×CELL clocks.
- pin_txd changes only at cell boundaries; it holds one value for exactly CELL clocks inside a frame.
- tx_valid held high while the block is busy: no acceptance until the STOP final clock or READY.
- fire low mid-frame: pin_txd drops to 0 asynchronously. The frame is abandoned and the byte is lost. The LEAD phase reruns after release.
- fire pulse shorter than one clock still performs a full reset.

## Test plan
- Reset release, tx_valid held 1 with tx_data=0xA5:
  - tx_ready rises exactly 8 clocks after release.
  - pin_txd over 40 clocks is cells 1,1,0,1,0,0,1,0,1,0, each 4 clocks wide.
- Back-to-back bytes 0x00 then 0xFF, tx_valid continuous:
  - Cell sequence is 1,0×8,0,1,1×8,0 with no gap.
  - tx_ready is high for exactly one clock between the frames.
  - busy stays 1 for 80 clocks.
- Drop tx_valid after the first byte:
  - Line stays 0 in READY; busy=0.
  - Reassert tx_valid with 0x81 20 clocks later: frame 1,1,0,0,0,0,0,0,1,0 starts the next clock.
- Toggle tx_data every clock while the block is busy:
  - Transmitted bits match only the value present on the accept edge.
- Assert fire low during data bit 3 of 0x5A:
  - pin_txd=0, tx_ready=0, busy=0 immediately.
  - After release, 8 idle clocks, then normal operation with the next byte.
- Loopback through the com_cc receive path with CELL=4 and bytes 0x3C, 0xC3, 0x55:
  - The recovered bit stream matches start/data/stop cells bit-for-bit.

Source files
------------

// File: rtl/com_cc_tx.sv
// Serial transmitter for the com link: one byte per 10-cell frame (start=1, 8 data MSB first, stop=0),
// each cell held for CELL clocks, idle line low.
module com_cc_tx #(
  parameter int CELL = 4,
  parameter int LEAD = 2
) (
  input  logic       clk,
  input  logic       fire,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       pin_txd,
  output logic       busy
);

  localparam int CW = (CELL > 1) ? $clog2(CELL) : 1;
  localparam int LW = (LEAD > 1) ? $clog2(LEAD) : 1;
  localparam logic [CW-1:0] CELL_LAST = CW'(CELL - 1);
  localparam logic [LW-1:0] LEAD_LAST = LW'(LEAD - 1);

  localparam logic [2:0] S_LEAD  = 3'd0;
  localparam logic [2:0] S_READY = 3'd1;
  localparam logic [2:0] S_START = 3'd2;
  localparam logic [2:0] S_DATA  = 3'd3;
  localparam logic [2:0] S_STOP  = 3'd4;

  logic [2:0]    state;
  logic [CW-1:0] cell_cnt;
  logic [LW-1:0] lead_cnt;
  logic [2:0]    bit_cnt;
  logic [7:0]    shift;
  logic          cell_end;
  logic          accept;

  assign cell_end = (cell_cnt == CELL_LAST);
  // The final STOP clock doubles as a READY slot so frames can run back to back.
  assign tx_ready = (state == S_READY) || ((state == S_STOP) && cell_end);
  assign accept   = tx_ready && tx_valid;
  assign busy     = (state == S_START) || (state == S_DATA) || (state == S_STOP);

  always_ff @(posedge clk or negedge fire) begin
    if (!fire) begin
      state    <= S_LEAD;
      cell_cnt <= '0;
      lead_cnt <= '0;
      bit_cnt  <= '0;
      shift    <= '0;
      pin_txd  <= 1'b0;
    end else begin
      case (state)
        S_LEAD: begin
          pin_txd <= 1'b0;
          if (cell_end) begin
            cell_cnt <= '0;
            if (lead_cnt == LEAD_LAST) begin
              lead_cnt <= '0;
              state    <= S_READY;
            end else begin
              lead_cnt <= lead_cnt + 1'b1;
            end
          end else begin
            cell_cnt <= cell_cnt + 1'b1;
          end
        end
        S_READY: begin
          pin_txd <= 1'b0;
          if (accept) begin
            shift    <= tx_data;
            cell_cnt <= '0;
            bit_cnt  <= '0;
            state    <= S_START;
            pin_txd  <= 1'b1;
          end
        end
        S_START: begin
          if (cell_end) begin
            cell_cnt <= '0;
            state    <= S_DATA;
            pin_txd  <= shift[7];
          end else begin
            cell_cnt <= cell_cnt + 1'b1;
          end
        end
        S_DATA: begin
          if (cell_end) begin
            cell_cnt <= '0;
            shift    <= {shift[6:0], 1'b0};
            if (bit_cnt == 3'd7) begin
              bit_cnt <= '0;
              state   <= S_STOP;
              pin_txd <= 1'b0;
            end else begin
              bit_cnt <= bit_cnt + 3'd1;
              // next bit is the one about to shift into the MSB
              pin_txd <= shift[6];
            end
          end else begin
            cell_cnt <= cell_cnt + 1'b1;
          end
        end
        S_STOP: begin
          if (cell_end) begin
            cell_cnt <= '0;
            bit_cnt  <= '0;
            if (accept) begin
              shift   <= tx_data;
              state   <= S_START;
              pin_txd <= 1'b1;
            end else begin
              state   <= S_READY;
              pin_txd <= 1'b0;
            end
          end else begin
            cell_cnt <= cell_cnt + 1'b1;
          end
        end
        default: begin
          state    <= S_LEAD;
          cell_cnt <= '0;
          lead_cnt <= '0;
          pin_txd  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_com_cc_tx.sv
// Directed bench for com_cc_tx: framing, handshake, back-to-back, async reset and a majority-vote receive model.
module tb_com_cc_tx;

  logic       clk = 1'b0;
  logic       fire = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready;
  logic       pin_txd;
  logic       busy;

  int n_cmp = 0;
  int n_fail = 0;

  com_cc_tx #(.CELL(4), .LEAD(2)) dut (
    .clk(clk), .fire(fire), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .pin_txd(pin_txd), .busy(busy)
  );

  always #5 clk = ~clk;

  // receive-side model: lock on first high sample, majority-vote each 4-sample window, 10 cells per frame
  logic       rx_en = 1'b0;
  logic       rx_lock = 1'b0;
  int         rx_smp = 0;
  int         rx_ones = 0;
  int         rx_cells = 0;
  logic [9:0] rx_sh = '0;
  logic [9:0] rx_frm [0:7];
  int         rx_n = 0;
  logic       rx_bit;
  assign rx_bit = ((rx_ones + int'(pin_txd)) * 2) > 4;

  always @(negedge clk) begin
    if (!rx_en) begin
      rx_lock <= 1'b0;
    end else if (!rx_lock) begin
      if (pin_txd) begin
        rx_lock  <= 1'b1;
        rx_smp   <= 1;
        rx_ones  <= 1;
        rx_cells <= 0;
        rx_sh    <= '0;
      end
    end else if (rx_smp == 3) begin
      rx_smp  <= 0;
      rx_ones <= 0;
      if (rx_cells == 9) begin
        if (rx_n < 8) rx_frm[rx_n] <= {rx_sh[8:0], rx_bit};
        rx_n    <= rx_n + 1;
        rx_lock <= 1'b0;
      end else begin
        rx_sh    <= {rx_sh[8:0], rx_bit};
        rx_cells <= rx_cells + 1;
      end
    end else begin
      rx_smp  <= rx_smp + 1;
      rx_ones <= rx_ones + int'(pin_txd);
    end
  end

  function automatic logic [39:0] cells40(input logic [9:0] e);
    logic [39:0] r;
    for (int c = 0; c < 40; c++) r[c] = e[9 - c / 4];
    return r;
  endfunction

  // sample the 40 clocks after the next edge (the accept edge when ready&valid)
  task automatic capture(input bit toggle, output logic [39:0] ps, output logic [39:0] bs,
                         output logic [39:0] rs);
    for (int c = 0; c < 40; c++) begin
      @(posedge clk); #1;
      ps[c] = pin_txd;
      bs[c] = busy;
      rs[c] = tx_ready;
      if (toggle) tx_data = ~tx_data;
    end
  endtask

  task automatic test_reset;
    logic [39:0] ps, bs, rs;
    int n, bad;
    tx_valid = 1'b1;
    tx_data  = 8'hA5;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++; if (pin_txd !== 1'b0) begin n_fail++; $display("FAIL reset_pin got %b want 0", pin_txd); end
    n_cmp++; if (tx_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready got %b want 0", tx_ready); end
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
    @(negedge clk);
    fire = 1'b1;
    n = 0; bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      n++;
      if (pin_txd !== 1'b0 || busy !== 1'b0) bad++;
      if (tx_ready === 1'b1) break;
    end
    n_cmp++; if (n !== 8) begin n_fail++; $display("FAIL lead_len got %0d clocks want 8", n); end
    n_cmp++; if (bad !== 0) begin n_fail++; $display("FAIL lead_idle got %0d bad clocks want 0", bad); end
    capture(1'b0, ps, bs, rs);
    tx_valid = 1'b0;
    n_cmp++; if (ps !== cells40(10'b1101001010)) begin n_fail++; $display("FAIL frame_a5 got %h want %h", ps, cells40(10'b1101001010)); end
    n_cmp++; if (bs !== {40{1'b1}}) begin n_fail++; $display("FAIL busy_a5 got %h want ffffffffff", bs); end
    n_cmp++; if (rs !== 40'h80_0000_0000) begin n_fail++; $display("FAIL ready_a5 got %h want 8000000000", rs); end
  endtask

  task automatic test_back_to_back;
    logic [39:0] p1, b1, r1, p2, b2, r2;
    tx_data  = 8'h00;
    tx_valid = 1'b1;
    capture(1'b0, p1, b1, r1);
    tx_data = 8'hFF;
    capture(1'b0, p2, b2, r2);
    tx_valid = 1'b0;
    n_cmp++; if (p1 !== cells40(10'b1000000000)) begin n_fail++; $display("FAIL b2b_frame00 got %h want %h", p1, cells40(10'b1000000000)); end
    n_cmp++; if (p2 !== cells40(10'b1111111110)) begin n_fail++; $display("FAIL b2b_frameff got %h want %h", p2, cells40(10'b1111111110)); end
    n_cmp++; if ({b1, b2} !== {80{1'b1}}) begin n_fail++; $display("FAIL b2b_busy got %h want all ones", {b1, b2}); end
    n_cmp++; if (r1 !== 40'h80_0000_0000) begin n_fail++; $display("FAIL b2b_ready1 got %h want 8000000000", r1); end
    n_cmp++; if (r2 !== 40'h80_0000_0000) begin n_fail++; $display("FAIL b2b_ready2 got %h want 8000000000", r2); end
  endtask

  task automatic test_idle_restart;
    logic [39:0] ps, bs, rs;
    int bad;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (pin_txd !== 1'b0 || busy !== 1'b0 || tx_ready !== 1'b1) bad++;
    end
    n_cmp++; if (bad !== 0) begin n_fail++; $display("FAIL idle_ready got %0d bad clocks want 0", bad); end
    tx_data  = 8'h81;
    tx_valid = 1'b1;
    capture(1'b0, ps, bs, rs);
    tx_valid = 1'b0;
    n_cmp++; if (ps !== cells40(10'b1100000010)) begin n_fail++; $display("FAIL frame_81 got %h want %h", ps, cells40(10'b1100000010)); end
  endtask

  task automatic test_data_toggle;
    logic [39:0] ps, bs, rs;
    tx_data  = 8'hC6;
    tx_valid = 1'b1;
    capture(1'b1, ps, bs, rs);
    tx_valid = 1'b0;
    n_cmp++; if (ps !== cells40(10'b1110001100)) begin n_fail++; $display("FAIL toggle_frame got %h want %h", ps, cells40(10'b1110001100)); end
    n_cmp++; if (rs !== 40'h80_0000_0000) begin n_fail++; $display("FAIL toggle_ready got %h want 8000000000", rs); end
  endtask

  task automatic test_fire_midframe;
    int n, bad;
    tx_data  = 8'h5A;
    tx_valid = 1'b1;
    for (int c = 0; c < 18; c++) begin
      @(posedge clk); #1;
      tx_valid = 1'b0;
    end
    n_cmp++; if (pin_txd !== 1'b1) begin n_fail++; $display("FAIL bit3_5a got %b want 1", pin_txd); end
    #2 fire = 1'b0;
    #1;
    n_cmp++; if (pin_txd !== 1'b0) begin n_fail++; $display("FAIL fire_pin got %b want 0", pin_txd); end
    n_cmp++; if (tx_ready !== 1'b0) begin n_fail++; $display("FAIL fire_ready got %b want 0", tx_ready); end
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL fire_busy got %b want 0", busy); end
    #4 fire = 1'b1;
    n = 0; bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      n++;
      if (pin_txd !== 1'b0 || busy !== 1'b0) bad++;
      if (tx_ready === 1'b1) break;
    end
    n_cmp++; if (n !== 8) begin n_fail++; $display("FAIL relead_len got %0d clocks want 8", n); end
    n_cmp++; if (bad !== 0) begin n_fail++; $display("FAIL relead_idle got %0d bad clocks want 0", bad); end
  endtask

  task automatic test_loopback;
    rx_en    = 1'b1;
    tx_data  = 8'h3C;
    tx_valid = 1'b1;
    repeat (40) begin @(posedge clk); #1; end
    tx_data = 8'hC3;
    repeat (40) begin @(posedge clk); #1; end
    tx_data = 8'h55;
    repeat (40) begin @(posedge clk); #1; end
    tx_valid = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    n_cmp++; if (rx_n !== 3) begin n_fail++; $display("FAIL rx_count got %0d want 3", rx_n); end
    n_cmp++; if (rx_frm[0] !== 10'b1001111000) begin n_fail++; $display("FAIL rx_3c got %b want 1001111000", rx_frm[0]); end
    n_cmp++; if (rx_frm[1] !== 10'b1110000110) begin n_fail++; $display("FAIL rx_c3 got %b want 1110000110", rx_frm[1]); end
    n_cmp++; if (rx_frm[2] !== 10'b1010101010) begin n_fail++; $display("FAIL rx_55 got %b want 1010101010", rx_frm[2]); end
  endtask

  initial begin
    for (int i = 0; i < 8; i++) rx_frm[i] = '0;
    test_reset;
    test_back_to_back;
    test_idle_restart;
    test_data_toggle;
    test_fire_midframe;
    test_loopback;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
